// File: rtl/rgb_pkg.sv
// Shared constants and the reset-palette helper for rgb_palette_converter.
package rgb_pkg;

    localparam int DEF_CH_W = 8;
    localparam int MAX_CH_W = 32;

    // Channel slots within a packed {R,G,B} word; bit offset = slot * CH_W.
    localparam int R_LSB = 2;
    localparam int G_LSB = 1;
    localparam int B_LSB = 0;

    // Reset contents of entry idx: each channel is all-ones or all-zeros from idx[2:0].
    function automatic logic [3*MAX_CH_W-1:0] default_entry(input int idx, input int ch_w);
        logic [3*MAX_CH_W-1:0] e;
        e = '0;
        for (int b = 0; b < MAX_CH_W; b++) begin
            if (b < ch_w) begin
                e[R_LSB*ch_w + b] = idx[2];
                e[G_LSB*ch_w + b] = idx[1];
                e[B_LSB*ch_w + b] = idx[0];
            end
        end
        return e;
    endfunction

endpackage

// File: rtl/rgb_palette_converter_if.sv
// Index-in / RGB-out stream bundle for rgb_palette_converter.
interface rgb_palette_converter_if
    import rgb_pkg::*;
#(
    parameter int IDX_W = 3,
    parameter int CH_W  = DEF_CH_W
);
    // Both streams: a word moves on any cycle where valid && ready are high.
    // The producer may change valid/data freely; only transfer cycles count.
    logic [IDX_W-1:0]  colour;
    logic              in_valid;
    logic              in_ready;
    logic [3*CH_W-1:0] rgb;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  colour, in_valid, out_ready,
        output in_ready, rgb, out_valid
    );

    modport master (
        output colour, in_valid, out_ready,
        input  in_ready, rgb, out_valid
    );
endinterface

// File: rtl/rgb_palette_ram.sv
// Palette storage: one write port, one registered read port, read-before-write.
module rgb_palette_ram
    import rgb_pkg::*;
#(
    parameter int IDX_W = 3,
    parameter int CH_W  = DEF_CH_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [3*CH_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [3*CH_W-1:0] rd_data
);
    localparam int DEPTH = 1 << IDX_W;
    localparam int W     = 3 * CH_W;

    logic [W-1:0] mem [DEPTH];

    // Nonblocking update means a same-edge read sees the previous entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= W'(default_entry(i, CH_W));
            end
            rd_data <= '0;
        end else begin
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end
endmodule

// File: rtl/rgb_palette_converter.sv
// Palette index to RGB converter, two-stage stallable pipeline.
// Optional brightness scaling in stage 2 when RGB_DIMMER_EN is defined.
module rgb_palette_converter
    import rgb_pkg::*;
#(
    parameter int IDX_W = 3,
    parameter int CH_W  = DEF_CH_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
`ifdef RGB_DIMMER_EN
    input  logic [CH_W-1:0]   brightness,
`endif
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [3*CH_W-1:0] wr_data,
    rgb_palette_converter_if.slave bus
);
    localparam int W = 3 * CH_W;

    logic         s1_valid;
    logic [W-1:0] s1_data;
    logic [W-1:0] s2_data;
    logic         s1_load;
    logic         s2_load;
    logic         accept;

    assign s2_load      = enable && (!bus.out_valid || bus.out_ready);
    assign s1_load      = enable && (!s1_valid || s2_load);
    assign bus.in_ready = s1_load && !rst;
    assign accept       = bus.in_valid && bus.in_ready;

    rgb_palette_ram #(.IDX_W(IDX_W), .CH_W(CH_W)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (accept),
        .rd_addr (bus.colour),
        .rd_data (s1_data)
    );

`ifdef RGB_DIMMER_EN
    // (ch * (b+1)) >> CH_W, so b = all-ones leaves the channel unchanged.
    function automatic logic [CH_W-1:0] dim_ch(input logic [CH_W-1:0] ch, input logic [CH_W-1:0] b);
        logic [2*CH_W:0] p;
        p = (2*CH_W+1)'(ch) * ((2*CH_W+1)'(b) + (2*CH_W+1)'(1));
        return p[2*CH_W-1:CH_W];
    endfunction

    for (genvar c = 0; c < 3; c++) begin : g_dim
        assign s2_data[c*CH_W +: CH_W] = dim_ch(s1_data[c*CH_W +: CH_W], brightness);
    end
`else
    assign s2_data = s1_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.rgb       <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= accept;
            end
            if (s2_load) begin
                bus.out_valid <= s1_valid;
                if (s1_valid) begin
                    bus.rgb <= s2_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_rgb_palette_converter.sv
// Self-checking bench for rgb_palette_converter (IDX_W=3, CH_W=8); covers RGB_DIMMER_EN when defined.
module tb_rgb_palette_converter;
    import rgb_pkg::*;

    localparam int IDX_W = 3;
    localparam int CH_W  = 8;
    localparam int W     = 24;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [W-1:0]     wr_data;
`ifdef RGB_DIMMER_EN
    logic [CH_W-1:0]  brightness;
`endif

    rgb_palette_converter_if #(.IDX_W(IDX_W), .CH_W(CH_W)) bus ();

    rgb_palette_converter #(.IDX_W(IDX_W), .CH_W(CH_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
`ifdef RGB_DIMMER_EN
        .brightness (brightness),
`endif
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic [W-1:0] ref_pal [8];
    bit           prev_hold = 1'b0;
    logic [W-1:0] prev_rgb;
    logic [W-1:0] mon_e;
    int           stall_seen = 0;

    typedef struct {
        logic [IDX_W-1:0] colour;
        logic [W-1:0]     exp_rgb;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_default(input int i);
        int r, g, b;
        r = ((i / 4) % 2) * 255;
        g = ((i / 2) % 2) * 255;
        b = (i % 2) * 255;
        return W'(r * 65536 + g * 256 + b);
    endfunction

    function automatic logic [W-1:0] ref_dim(input logic [W-1:0] v, input int bright);
        int r, g, b;
        r = (int'(v[23:16]) * (bright + 1)) / 256;
        g = (int'(v[15:8])  * (bright + 1)) / 256;
        b = (int'(v[7:0])   * (bright + 1)) / 256;
        return W'(r * 65536 + g * 256 + b);
    endfunction

    // Reference model and scoreboard, sampled mid-cycle when all inputs are settled.
    always @(negedge clk) begin
        if (rst) begin
            check("in_ready_in_reset", 32'(bus.in_ready), 32'd0);
            exp_q.delete();
            for (int i = 0; i < 8; i++) ref_pal[i] = ref_default(i);
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("stall_rgb_hold", 32'(bus.rgb), 32'(prev_rgb));
                check("stall_valid_hold", 32'(bus.out_valid), 32'd1);
            end
            if (bus.in_valid && !bus.in_ready) stall_seen++;
            if (bus.out_valid && bus.out_ready && enable) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow: got %h expected nothing", bus.rgb);
                end else begin
                    mon_e = exp_q.pop_front();
`ifdef RGB_DIMMER_EN
                    mon_e = ref_dim(mon_e, int'(brightness));
`endif
                    check("scoreboard", 32'(bus.rgb), 32'(mon_e));
                end
                got_q.push_back(bus.rgb);
            end
            if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_pal[bus.colour]);
            if (wr_en) ref_pal[wr_addr] = wr_data;
            prev_hold = bus.out_valid && !(bus.out_ready && enable);
            prev_rgb  = bus.rgb;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IDX_W-1:0] c);
        bit done;
        done = 1'b0;
        bus.colour   = c;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (bus.in_ready) done = 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no in_ready expected accept of %0d", c);
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        step();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{3'd0, 24'h000000};
        vecs[1] = '{3'd1, 24'h0000FF};
        vecs[2] = '{3'd2, 24'h00FF00};
        vecs[3] = '{3'd3, 24'h00FFFF};
        vecs[4] = '{3'd4, 24'hFF0000};
        vecs[5] = '{3'd5, 24'hFF00FF};
        vecs[6] = '{3'd6, 24'hFFFF00};
        vecs[7] = '{3'd7, 24'hFFFFFF};

        rst = 1'b1; enable = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        bus.colour = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
`ifdef RGB_DIMMER_EN
        brightness = 8'hFF;
`endif
        step();
        step();
        @(negedge clk);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_rgb", 32'(bus.rgb), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
        step();

        // Default palette streamed back to back; output trails input by 2 cycles.
        got_q.delete();
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                bus.colour   = vecs[i].colour;
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 8) check("t1_in_ready", 32'(bus.in_ready), 32'd1);
            if (i >= 2) begin
                check("t1_out_valid", 32'(bus.out_valid), 32'd1);
                check("t1_rgb", 32'(bus.rgb), 32'(vecs[i-2].exp_rgb));
            end else begin
                check("t1_latency", 32'(bus.out_valid), 32'd0);
            end
            step();
        end
        drain();

        // Same-cycle write and read of entry 5.
        got_q.delete();
        bus.colour = 3'd5; bus.in_valid = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 24'h123456;
        @(negedge clk);
        check("t2_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        wr_en = 1'b0;
        @(negedge clk);
        step();
        bus.in_valid = 1'b0;
        drain();
        check("t2_count", 32'(got_q.size()), 32'd2);
        check("t2_old_entry", 32'(got_q[0]), 32'hFF00FF);
        check("t2_new_entry", 32'(got_q[1]), 32'h123456);

        // Backpressure mid-stream.
        got_q.delete();
        stall_seen = 0;
        fork
            begin
                send(3'd1); send(3'd2); send(3'd3); send(3'd4);
            end
            begin
                step(); step();
                bus.out_ready = 1'b0;
                repeat (3) step();
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("t3_in_ready_dropped", 32'(stall_seen > 0), 32'd1);
        check("t3_count", 32'(got_q.size()), 32'd4);
        check("t3_rgb0", 32'(got_q[0]), 32'h0000FF);
        check("t3_rgb1", 32'(got_q[1]), 32'h00FF00);
        check("t3_rgb2", 32'(got_q[2]), 32'h00FFFF);
        check("t3_rgb3", 32'(got_q[3]), 32'hFF0000);

        // Freeze with enable low while both stages are full.
        got_q.delete();
        bus.out_ready = 1'b0;
        send(3'd6);
        send(3'd3);
        enable = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("t4_out_valid_frozen", 32'(bus.out_valid), 32'd1);
            check("t4_rgb_frozen", 32'(bus.rgb), 32'hFFFF00);
            check("t4_in_ready_low", 32'(bus.in_ready), 32'd0);
            step();
        end
        check("t4_no_transfer", 32'(got_q.size()), 32'd0);
        enable = 1'b1;
        drain();
        check("t4_count", 32'(got_q.size()), 32'd2);
        check("t4_rgb0", 32'(got_q[0]), 32'hFFFF00);
        check("t4_rgb1", 32'(got_q[1]), 32'h00FFFF);

        // Reset with data in flight; palette write before reset and during reset are lost.
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 24'hABCDEF;
        step();
        wr_en = 1'b0;
        bus.out_ready = 1'b0;
        send(3'd1);
        send(3'd4);
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 24'h111111;
        @(negedge clk);
        check("t5_in_ready_rst", 32'(bus.in_ready), 32'd0);
        step();
        rst = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        check("t5_out_valid", 32'(bus.out_valid), 32'd0);
        check("t5_rgb", 32'(bus.rgb), 32'd0);
        check("t5_in_ready_back", 32'(bus.in_ready), 32'd1);
        step();
        bus.out_ready = 1'b1;
        got_q.delete();
        send(3'd1);
        send(3'd2);
        drain();
        check("t5_count", 32'(got_q.size()), 32'd2);
        check("t5_default1", 32'(got_q[0]), 32'h0000FF);
        check("t5_default2", 32'(got_q[1]), 32'h00FF00);

`ifdef RGB_DIMMER_EN
        got_q.delete();
        brightness = 8'h7F;
        send(3'd7);
        drain();
        brightness = 8'hFF;
        send(3'd7);
        drain();
        brightness = 8'h00;
        send(3'd7);
        drain();
        brightness = 8'hFF;
        check("dim_count", 32'(got_q.size()), 32'd3);
        check("dim_7f", 32'(got_q[0]), 32'h7F7F7F);
        check("dim_ff", 32'(got_q[1]), 32'hFFFFFF);
        check("dim_00", 32'(got_q[2]), 32'h000000);
`endif

        // Random traffic against the reference model.
        for (int i = 0; i < 500; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.colour    = IDX_W'($urandom_range(0, 7));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            enable        = ($urandom_range(0, 7) != 0);
            wr_en         = ($urandom_range(0, 5) == 0);
            wr_addr       = IDX_W'($urandom_range(0, 7));
            wr_data       = W'($urandom);
            step();
        end
        bus.in_valid = 1'b0;
        wr_en = 1'b0;
        enable = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rgb_palette_converter.md
# rgb_palette_converter

Parametrised colour-index to RGB converter for the video datapath. Accepts a stream of palette indices with valid/ready handshaking, looks each index up in a run-time-writable palette, and emits packed RGB words through a two-stage stallable pipeline. It sits between the pattern/colour generator and the display output stage. It generalises the fixed 3-bit-to-24-bit converter to wider indices and configurable channel depth, and adds a writable palette and backpressure.

## Interface
Parameters:
- IDX_W, 3: index width; palette depth DEPTH = 2**IDX_W; IDX_W >= 3 required
- CH_W, 8: bits per colour channel; rgb width = 3*CH_W

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- enable  in  1  pipeline run; 0 freezes the pipeline
- colour  in  IDX_W  palette index
- in_valid  in  1  colour valid
- in_ready  out  1  converter can accept colour this cycle
- rgb  out  3*CH_W  {R,G,B}; R in MSBs
- out_valid  out  1  rgb valid
- out_ready  in  1  downstream accepts rgb
- wr_en  in  1  palette write strobe
- wr_addr  in  IDX_W  palette entry to write
- wr_data  in  3*CH_W  new {R,G,B} entry

## Operation
- Input transfer occurs on a cycle with in_valid && in_ready. Output transfer occurs on a cycle with out_valid && out_ready.
- Stage 1 performs a synchronous palette read and registers the index result plus s1_valid.
- Stage 2 is the output register holding rgb and out_valid. Without the dimmer, stage 2 is a pass-through register.
- Advance rules:
  - s2 loads when enable && (!out_valid || out_ready).
  - s1 loads when enable && (!s1_valid || s2 loads).
  - in_ready = enable && (!s1_valid || s2 loads). in_ready is combinational from out_ready and enable.
- When enable = 0: no transfers, all pipeline registers hold, out_valid holds its value, rgb holds. Palette writes still occur.
- Palette:
  - DEPTH entries of 3*CH_W bits.
  - A write on wr_en takes effect at the clock edge.
  - A read of the same entry accepted in the same cycle returns the OLD entry (read-before-write). Reads accepted the next cycle return the new entry.
- Reset:
  - Reloads the default palette: entry i = {R={CH_W{i[2]}}, G={CH_W{i[1]}}, B={CH_W{i[0]}}}. Index bits above bit 2 are ignored for the default.
  - Clears s1_valid and out_valid. rgb resets to 0.
  - wr_en is ignored during reset.
- Reset mid-stream: in-flight data is discarded. in_ready = 0 during the reset cycle and returns to enable on the next cycle.
- Data ordering is strictly FIFO. Nothing is dropped or duplicated under any out_ready pattern.

## Timing
- Latency: 2 cycles from input transfer to out_valid, given out_ready = 1 and enable = 1.
- Throughput: one index per cycle when out_ready is held at 1.
- Stall: while out_valid && !out_ready, rgb and out_valid are stable. Up to 2 items are held internally.
- Reset values: in_ready = 0 during rst, out_valid = 0, rgb = 0.

## Configuration
- RGB_DIMMER_EN defined:
  - Adds input port brightness [CH_W-1:0].
  - Stage 2 computes, per channel, out = (ch * (brightness+1)) >> CH_W, truncated to CH_W bits. brightness = all-ones is identity; brightness = 0 yields ch >> CH_W = 0.
  - brightness is sampled when s2 loads.
  - Latency is unchanged.
- RGB_DIMMER_EN undefined: no brightness port; stage 2 passes the palette data through unchanged.

## Structure
- Package rgb_pkg holds:
  - default CH_W
  - channel offset constants R_LSB/G_LSB/B_LSB as multiples of CH_W
  - function default_entry(idx, ch_w) for reset palette contents
- Sub-module rgb_palette_ram: DEPTH x 3*CH_W register array with one write port and one synchronous read port with read-enable. It implements read-before-write and the reset reload.
- The top level holds the handshake, valid bits, and stage 2 (dimmer).

## Test plan
- Reset, then stream colours 0..7 with out_ready = 1, IDX_W = 3, CH_W = 8 -> rgb 000000, 0000FF, 00FF00, 00FFFF, FF0000, FF00FF, FFFF00, FFFFFF, each 2 cycles after input; out_valid contiguous.
- Write entry 5 = 123456 while index 5 is accepted the same cycle, then send 5 again -> outputs FF00FF then 123456.
- Stream 1,2,3,4 with out_ready low for 3 cycles mid-stream -> in_ready drops; rgb is held stable while stalled; output order is 0000FF, 00FF00, 00FFFF, FF0000 with no loss or duplication.
- Drop enable for 4 cycles with 2 items in flight -> no transfers and outputs frozen; after enable returns, the remaining items emerge in order.
- Assert rst with 2 items in flight and after writing entry 1 = ABCDEF -> out_valid = 0 and rgb = 0; a subsequent index 1 returns 0000FF.
- With RGB_DIMMER_EN, brightness = 0x7F, index 7 -> rgb 7F7F7F; brightness = 0xFF -> FFFFFF; brightness = 0 -> 000000.
